// File: rtl/ble_packet_rx_to_host_pkg.sv
// ble_packet_rx_to_host_pkg
//   Shared definitions for the BLE receive -> host UART return path:
//   default keys/addresses, packet field offsets, error codes, FSM state
//   encodings, the CRC-24 polynomial and small datapath helpers.
package ble_packet_rx_to_host_pkg;

  localparam logic [31:0] ACCESS_ADDR_DEF = 32'h8E89BED6;
  localparam logic [23:0] CRC_INIT_DEF    = 24'h555555;
  localparam logic [15:0] KEY_WORD_DEF    = 16'hA5C3;
  localparam logic [7:0]  SOF_DEF         = 8'h7E;
  localparam logic [7:0]  EOF_DEF         = 8'h7F;

  localparam logic [7:0]  PREAMBLE        = 8'hAA;
  localparam logic [23:0] CRC_POLY        = 24'h00065B;
  localparam logic [3:0]  MAX_LEN         = 4'd8;

  // Packet field offsets (LSB of each field in the 144-bit packet)
  localparam int PKT_W    = 144;
  localparam int FRAME_W  = 96;
  localparam int PRE_LSB  = 136;
  localparam int AA_LSB   = 104;
  localparam int CMD_LSB  = 100;
  localparam int LEN_LSB  = 96;
  localparam int PAY_LSB  = 24;
  localparam int CRC_LSB  = 0;
  localparam int BODY_LSB = 24;   // CRC covers [103:24]
  localparam int BODY_W   = 80;

  // Down-counter loads; each phase ends when the counter reaches zero
  localparam logic [6:0] CRC_CNT_LOAD  = 7'd79;
  localparam logic [6:0] WORD_CNT_LOAD = 7'd3;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_HDR  = 2'b01,
    ERR_CRC  = 2'b10,
    ERR_LEN  = 2'b11
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_CRC     = 3'd2,
    S_DECRYPT = 3'd3,
    S_BUILD   = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  // One MSB-first step of the CRC-24 LFSR
  function automatic logic [23:0] crc24_step(input logic [23:0] crc, input logic bit_in);
    logic fb;
    fb = crc[23] ^ bit_in;
    return {crc[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h000000);
  endfunction

  // Zero every payload byte whose index is >= len; byte 0 is [63:56]
  function automatic logic [63:0] mask_payload(input logic [63:0] data, input logic [3:0] len);
    logic [63:0] m;
    m = data;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) >= len) m[63-8*k -: 8] = 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/ble_packet_rx_to_host_crc24_serial.sv
// ble_packet_rx_to_host_crc24_serial
//   Bit-serial CRC-24 (x^24+x^10+x^9+x^6+x^4+x^3+x+1), MSB first.
//   Ports:
//     clk     in   clock, rising edge
//     reset   in   asynchronous active-low reset
//     init    in   load CRC_INIT (has priority over en)
//     en      in   shift one bit_in into the LFSR
//     bit_in  in   serial data bit
//     crc     out  current LFSR contents
module ble_packet_rx_to_host_crc24_serial
  import ble_packet_rx_to_host_pkg::*;
#(
  parameter logic [23:0] CRC_INIT = CRC_INIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [23:0] crc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc <= 24'h000000;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc24_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/ble_packet_rx_to_host.sv
// ble_packet_rx_to_host
//   Accepts one 144-bit BLE packet, checks preamble / access address / length
//   and CRC-24, OTP-decrypts the 64-bit payload and presents a 96-bit host
//   UART frame until the host acknowledges it.
//   Ports:
//     clk             in   clock, rising edge
//     reset           in   asynchronous active-low reset
//     ble_packet      in   received packet, captured on acceptance
//     packet_valid    in   1-cycle strobe for ble_packet
//     decrypt_bypass  in   1 = payload passes unchanged (captured on acceptance)
//     host_ack        in   host has taken host_frame (honoured only in HOLD)
//     host_frame      out  {SOF, 0,cmd, 0,len, payload, EOF}
//     frame_valid     out  host_frame valid, held until host_ack
//     busy            out  high in every state except IDLE
//     error           out  last accepted packet failed
//     error_code      out  01 header, 10 CRC, 11 length, 00 none
//     overrun         out  sticky: packet_valid seen while busy
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for packet_valid
//   CHECK   | preamble / access address / length check (first CRC bit)
//   CRC     | remaining CRC bits, then compare against received CRC
//   DECRYPT | one 16-bit payload word per cycle, high word first
//   BUILD   | mask bytes beyond len, assemble host_frame
//   HOLD    | frame_valid high until host_ack
module ble_packet_rx_to_host
  import ble_packet_rx_to_host_pkg::*;
#(
  parameter logic [31:0] ACCESS_ADDR = ACCESS_ADDR_DEF,
  parameter logic [23:0] CRC_INIT    = CRC_INIT_DEF,
  parameter logic [15:0] KEY_WORD    = KEY_WORD_DEF,
  parameter logic [7:0]  SOF         = SOF_DEF,
  parameter logic [7:0]  EOF         = EOF_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PKT_W-1:0]     ble_packet,
  input  logic                 packet_valid,
  input  logic                 decrypt_bypass,
  input  logic                 host_ack,
  output logic [FRAME_W-1:0]   host_frame,
  output logic                 frame_valid,
  output logic                 busy,
  output logic                 error,
  output logic [1:0]           error_code,
  output logic                 overrun
);

  state_t      state, state_n;

  logic [7:0]  cap_pre;
  logic [31:0] cap_aa;
  logic [3:0]  cap_cmd;
  logic [3:0]  cap_len;
  logic [63:0] cap_pay;
  logic [23:0] cap_crc;
  logic        cap_byp;

  logic [BODY_W-1:0] body_sh;
  logic [6:0]  cnt;
  logic [63:0] dec;
  logic [15:0] dec_word;
  logic [23:0] crc_out;

  logic        accept;
  logic        crc_init;
  logic        crc_en;
  logic        set_err;
  err_code_t   code_n;
  logic        hdr_bad;
  logic        len_bad;

  assign hdr_bad  = (cap_pre != PREAMBLE) || (cap_aa != ACCESS_ADDR);
  assign len_bad  = (cap_len > MAX_LEN);
  // cnt counts 3..0 in DECRYPT, so cnt[1:0] selects the high word first
  assign dec_word = cap_pay[{cnt[1:0], 4'b0000} +: 16] ^ (cap_byp ? 16'h0000 : KEY_WORD);

  assign frame_valid = (state == S_HOLD);
  assign busy        = (state != S_IDLE);

  // The LFSR is seeded on acceptance and starts shifting in CHECK, so the
  // final CRC is ready on the last CRC-state cycle and a mismatch reports
  // on the same edge that would otherwise enter DECRYPT.
  ble_packet_rx_to_host_crc24_serial #(
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .clk    (clk),
    .reset  (reset),
    .init   (crc_init),
    .en     (crc_en),
    .bit_in (body_sh[BODY_W-1]),
    .crc    (crc_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    set_err  = 1'b0;
    code_n   = ERR_NONE;
    case (state)
      S_IDLE: begin
        if (packet_valid) begin
          accept   = 1'b1;
          crc_init = 1'b1;
          state_n  = S_CHECK;
        end
      end
      S_CHECK: begin
        crc_en = 1'b1;
        if (hdr_bad) begin
          set_err = 1'b1;
          code_n  = ERR_HDR;
          state_n = S_IDLE;
        end else if (len_bad) begin
          set_err = 1'b1;
          code_n  = ERR_LEN;
          state_n = S_IDLE;
        end else begin
          state_n = S_CRC;
        end
      end
      S_CRC: begin
        if (cnt != 7'd0) begin
          crc_en = 1'b1;
        end else if (crc_out != cap_crc) begin
          set_err = 1'b1;
          code_n  = ERR_CRC;
          state_n = S_IDLE;
        end else begin
          state_n = S_DECRYPT;
        end
      end
      S_DECRYPT: begin
        if (cnt == 7'd0) state_n = S_BUILD;
      end
      S_BUILD: state_n = S_HOLD;
      S_HOLD: begin
        if (host_ack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_pre    <= 8'h00;
      cap_aa     <= 32'h0;
      cap_cmd    <= 4'h0;
      cap_len    <= 4'h0;
      cap_pay    <= 64'h0;
      cap_crc    <= 24'h0;
      cap_byp    <= 1'b0;
      body_sh    <= '0;
      cnt        <= 7'd0;
      dec        <= 64'h0;
      host_frame <= '0;
      error      <= 1'b0;
      error_code <= 2'b00;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        cap_pre <= ble_packet[PRE_LSB +: 8];
        cap_aa  <= ble_packet[AA_LSB +: 32];
        cap_cmd <= ble_packet[CMD_LSB +: 4];
        cap_len <= ble_packet[LEN_LSB +: 4];
        cap_pay <= ble_packet[PAY_LSB +: 64];
        cap_crc <= ble_packet[CRC_LSB +: 24];
        cap_byp <= decrypt_bypass;
        body_sh <= ble_packet[BODY_LSB +: BODY_W];
      end else if (crc_en) begin
        body_sh <= {body_sh[BODY_W-2:0], 1'b0};
      end

      case (state)
        S_CHECK: cnt <= CRC_CNT_LOAD;
        S_CRC:   cnt <= (cnt != 7'd0) ? cnt - 7'd1 : WORD_CNT_LOAD;
        S_DECRYPT: begin
          dec <= {dec[47:0], dec_word};
          cnt <= cnt - 7'd1;
        end
        S_BUILD: host_frame <= {SOF, 4'h0, cap_cmd, 4'h0, cap_len,
                                mask_payload(dec, cap_len), EOF};
        default: ;
      endcase

      if (accept) begin
        error      <= 1'b0;
        error_code <= ERR_NONE;
        overrun    <= 1'b0;
      end else begin
        if (set_err) begin
          error      <= 1'b1;
          error_code <= code_n;
        end
        if (packet_valid && (state != S_IDLE)) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ble_packet_rx_to_host.sv
// Testbench for ble_packet_rx_to_host: directed packets, expected responses
// queued by the driver and checked by an independent monitor.
module tb_ble_packet_rx_to_host;

  localparam logic [31:0] AA_OK = 32'h8E89BED6;
  localparam logic [63:0] PAY   = 64'h0123456789ABCDEF;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [143:0] ble_packet = '0;
  logic         packet_valid = 1'b0;
  logic         decrypt_bypass = 1'b0;
  logic         host_ack = 1'b0;
  logic [95:0]  host_frame;
  logic         frame_valid;
  logic         busy;
  logic         error;
  logic [1:0]   error_code;
  logic         overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_delay = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ble_packet_rx_to_host dut (
    .clk            (clk),
    .reset          (reset),
    .ble_packet     (ble_packet),
    .packet_valid   (packet_valid),
    .decrypt_bypass (decrypt_bypass),
    .host_ack       (host_ack),
    .host_frame     (host_frame),
    .frame_valid    (frame_valid),
    .busy           (busy),
    .error          (error),
    .error_code     (error_code),
    .overrun        (overrun)
  );

  typedef struct {
    bit          is_frame;
    logic [95:0] frame;
    logic [1:0]  code;
    logic        ovr;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] crc_model(input logic [79:0] d);
    logic [23:0] c;
    logic fb;
    c = 24'h555555;
    for (int i = 79; i >= 0; i--) begin
      fb = c[23] ^ d[i];
      c = {c[22:0], 1'b0};
      if (fb) c = c ^ 24'h00065B;
    end
    return c;
  endfunction

  function automatic logic [143:0] mk(input logic [31:0] aa, input logic [3:0] cmd,
                                     input logic [3:0] len, input logic [63:0] pay);
    logic [79:0] body;
    body = {cmd, len, 8'h00, pay};
    return {8'hAA, aa, body, crc_model(body)};
  endfunction

  function automatic logic [95:0] fr(input logic [3:0] cmd, input logic [3:0] len,
                                     input logic [63:0] pay);
    return {8'h7E, 4'h0, cmd, 4'h0, len, pay, 8'h7F};
  endfunction

  // Latencies count edges from the acceptance edge T to the edge that first samples the output
  function automatic exp_t ef(input logic [95:0] f, input logic ovr);
    exp_t e;
    e.is_frame = 1'b1; e.frame = f; e.code = 2'b00; e.ovr = ovr; e.lat = 87; e.t_acc = 0;
    return e;
  endfunction

  function automatic exp_t ee(input logic [1:0] code, input int lat);
    exp_t e;
    e.is_frame = 1'b0; e.frame = '0; e.code = code; e.ovr = 1'b0; e.lat = lat; e.t_acc = 0;
    return e;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || frame_valid) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (busy || frame_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: busy=%b frame_valid=%b, want 0 0", busy, frame_valid);
    end
  endtask

  task automatic send(input logic [143:0] p, input logic byp, input bit expect_it, input exp_t e);
    exp_t x;
    wait_idle();
    @(negedge clk);
    ble_packet     = p;
    decrypt_bypass = byp;
    packet_valid   = 1'b1;
    @(negedge clk);
    packet_valid   = 1'b0;
    if (expect_it) begin
      x = e;
      x.t_acc = cyc;
      sbq.push_back(x);
    end
  endtask

  // Monitor
  logic        fv_prev = 1'b0;
  logic        err_prev = 1'b0;
  logic [95:0] cur_frame = '0;
  bit          stab_bad = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (frame_valid && !fv_prev) begin
      if (sbq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_frame: got %h, want no frame", host_frame);
      end else begin
        e = sbq.pop_front();
        check("resp_kind_frame", 128'(1'b1), 128'(e.is_frame));
        check("host_frame", 128'(host_frame), 128'(e.frame));
        check("frame_error", 128'({error, error_code}), 128'(3'b000));
        check("frame_overrun", 128'(overrun), 128'(e.ovr));
        check("frame_latency", 128'(cyc + 1 - e.t_acc), 128'(e.lat));
        cur_frame = e.frame;
        stab_bad  = 1'b0;
      end
    end
    if (frame_valid && fv_prev && host_frame !== cur_frame) stab_bad = 1'b1;
    if (!frame_valid && fv_prev)
      check("frame_hold", 128'({host_frame, stab_bad}), 128'({cur_frame, 1'b0}));
    if (error && !err_prev) begin
      if (sbq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_error: got code %b, want no error", error_code);
      end else begin
        e = sbq.pop_front();
        check("resp_kind_error", 128'(1'b0), 128'(e.is_frame));
        check("error_code", 128'(error_code), 128'(e.code));
        check("error_latency", 128'(cyc + 1 - e.t_acc), 128'(e.lat));
      end
    end
    fv_prev  = frame_valid;
    err_prev = error;
  end

  // Host acknowledge model
  int hold_cnt = 0;
  bit ack_pend = 1'b0;

  always @(negedge clk) begin
    if (ack_pend) begin
      host_ack = 1'b0;
      ack_pend = 1'b0;
      check("ack_release", 128'({frame_valid, busy}), 128'(2'b00));
    end else if (frame_valid) begin
      if (hold_cnt >= ack_delay) begin
        host_ack = 1'b1;
        ack_pend = 1'b1;
        hold_cnt = 0;
      end else begin
        hold_cnt++;
      end
    end else begin
      hold_cnt = 0;
    end
  end

  initial begin
    logic [143:0] p;
    int k;

    repeat (3) @(negedge clk);
    check("rst_frame", 128'(host_frame), 128'(0));
    check("rst_flags", 128'({frame_valid, busy, error, error_code, overrun}), 128'(0));
    reset = 1'b1;
    @(negedge clk);

    ack_delay = 2;
    send(mk(AA_OK, 4'h1, 4'd8, PAY), 1'b0, 1, ef(fr(4'h1, 4'd8, 64'hA4E0E0A42C68682C), 1'b0));
    send(mk(AA_OK, 4'h1, 4'd8, PAY), 1'b1, 1, ef(fr(4'h1, 4'd8, PAY), 1'b0));
    send(mk(AA_OK, 4'h1, 4'd3, PAY), 1'b1, 1, ef(fr(4'h1, 4'd3, 64'h0123450000000000), 1'b0));
    send(mk(AA_OK, 4'h1, 4'd5, PAY), 1'b0, 1, ef(fr(4'h1, 4'd5, 64'hA4E0E0A42C000000), 1'b0));
    send(mk(AA_OK, 4'hF, 4'd0, PAY), 1'b0, 1, ef(fr(4'hF, 4'd0, 64'h0), 1'b0));

    p = mk(AA_OK, 4'h1, 4'd8, PAY);
    p[0] = ~p[0];
    send(p, 1'b0, 1, ee(2'b10, 82));
    send(mk(32'h0, 4'h1, 4'd8, PAY), 1'b0, 1, ee(2'b01, 2));
    p = mk(AA_OK, 4'h1, 4'd8, PAY);
    p[143:136] = 8'h55;
    send(p, 1'b0, 1, ee(2'b01, 2));
    send(mk(AA_OK, 4'h1, 4'd9, PAY), 1'b0, 1, ee(2'b11, 2));
    send(mk(32'h0, 4'h1, 4'd9, PAY), 1'b0, 1, ee(2'b01, 2));

    // Overrun mid-packet plus a 50-cycle host stall
    ack_delay = 50;
    send(mk(AA_OK, 4'h2, 4'd8, PAY), 1'b0, 1, ef(fr(4'h2, 4'd8, 64'hA4E0E0A42C68682C), 1'b1));
    repeat (39) @(negedge clk);
    ble_packet   = '1;
    packet_valid = 1'b1;
    @(negedge clk);
    packet_valid = 1'b0;

    // Next acceptance clears overrun
    ack_delay = 1;
    send(mk(AA_OK, 4'h3, 4'd8, 64'hFFFF0000A5C35A3C), 1'b1,
         1, ef(fr(4'h3, 4'd8, 64'hFFFF0000A5C35A3C), 1'b0));

    // Reset mid-packet
    send(mk(AA_OK, 4'h1, 4'd8, PAY), 1'b0, 0, ee(2'b00, 0));
    repeat (9) @(negedge clk);
    packet_valid = 1'b1;
    @(negedge clk);
    packet_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_rst_state", 128'({busy, overrun}), 128'(2'b11));
    reset = 1'b0;
    #1;
    check("rst_mid_frame", 128'(host_frame), 128'(0));
    check("rst_mid_flags", 128'({frame_valid, busy, error, error_code, overrun}), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    ack_delay = 0;
    send(mk(AA_OK, 4'h6, 4'd8, PAY), 1'b0, 1, ef(fr(4'h6, 4'd8, 64'hA4E0E0A42C68682C), 1'b0));

    // Back-to-back, acked on first valid cycle
    send(mk(AA_OK, 4'h7, 4'd8, PAY), 1'b1, 1, ef(fr(4'h7, 4'd8, PAY), 1'b0));
    send(mk(AA_OK, 4'h8, 4'd4, 64'h0000000000000000), 1'b0,
         1, ef(fr(4'h8, 4'd4, 64'hA5C3A5C300000000), 1'b0));

    k = 0;
    while (sbq.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    wait_idle();
    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL response_timeout: got %0d pending, want 0", sbq.size());
    end
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
